// File: rtl/watch_timekeeper.sv
// watch_timekeeper: binary seconds/minutes/hours timekeeper on a single clock.
// A built-in prescaler derives the seconds tick from clk. Supports run/stop,
// a validated load handshake and registered cascade carry pulses.
// Optional alarm comparator: define WATCH_ALARM_EN to add the alarm ports.
module watch_timekeeper #(
   parameter int unsigned PRESCALE = 32768,
   parameter int unsigned SEC_MAX  = 60,
   parameter int unsigned MIN_MAX  = 60,
   parameter int unsigned HOUR_MAX = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [5:0] load_sec,
   input  logic [5:0] load_min,
   input  logic [4:0] load_hour,
   output logic       load_err,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hour,
   output logic       sec_tick,
   output logic       min_carry,
   output logic       hour_carry,
   output logic       day_wrap
`ifdef WATCH_ALARM_EN
   ,
   input  logic       alarm_set,
   input  logic [5:0] alarm_min,
   input  logic [4:0] alarm_hour,
   input  logic       alarm_clr,
   output logic       alarm
`endif
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
   localparam logic [5:0]    SEC_LAST  = 6'(SEC_MAX - 1);
   localparam logic [5:0]    MIN_LAST  = 6'(MIN_MAX - 1);
   localparam logic [4:0]    HOUR_LAST = 5'(HOUR_MAX - 1);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e        r_state;
   state_e        w_state_nxt;

   logic [PW-1:0] r_presc;
   logic [5:0]    r_sec;
   logic [5:0]    r_min;
   logic [4:0]    r_hour;
   logic          r_sec_tick;
   logic          r_min_carry;
   logic          r_hour_carry;
   logic          r_day_wrap;
   logic          r_load_err;

   logic [PW-1:0] w_presc_nxt;
   logic [5:0]    w_sec_nxt;
   logic [5:0]    w_min_nxt;
   logic [4:0]    w_hour_nxt;
   logic          w_accept;
   logic          w_range_ok;
   logic          w_load_ok;
   logic          w_load_bad;
   logic          w_tick;
   logic          w_adv;
   logic          w_sec_wrap;
   logic          w_min_wrap;
   logic          w_hour_wrap;

   assign w_accept   = load_valid & load_ready;
   assign w_range_ok = ({1'b0, load_sec}  < 7'(SEC_MAX)) &&
                       ({1'b0, load_min}  < 7'(MIN_MAX)) &&
                       ({1'b0, load_hour} < 6'(HOUR_MAX));
   assign w_load_ok  = w_accept & w_range_ok;
   assign w_load_bad = w_accept & ~w_range_ok;

   // A good load overrides a coincident tick; a rejected load leaves time running.
   assign w_tick      = run & (r_presc == PRE_LAST);
   assign w_adv       = w_tick & ~w_load_ok;
   assign w_sec_wrap  = w_adv & (r_sec == SEC_LAST);
   assign w_min_wrap  = w_sec_wrap & (r_min == MIN_LAST);
   assign w_hour_wrap = w_min_wrap & (r_hour == HOUR_LAST);

   // Next prescaler and time values: load, cascade increment or hold
   always_comb begin
      w_presc_nxt = r_presc;
      w_sec_nxt   = r_sec;
      w_min_nxt   = r_min;
      w_hour_nxt  = r_hour;
      if (w_load_ok) begin
         w_presc_nxt = '0;
         w_sec_nxt   = load_sec;
         w_min_nxt   = load_min;
         w_hour_nxt  = load_hour;
      end else begin
         if (run) begin
            w_presc_nxt = (r_presc == PRE_LAST) ? '0 : r_presc + PW'(1);
         end
         if (w_adv) begin
            w_sec_nxt = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
            if (w_sec_wrap) begin
               w_min_nxt = w_min_wrap ? 6'd0 : r_min + 6'd1;
            end
            if (w_min_wrap) begin
               w_hour_nxt = w_hour_wrap ? 5'd0 : r_hour + 5'd1;
            end
         end
      end
   end

   // Time, prescaler and registered pulse outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc      <= '0;
         r_sec        <= '0;
         r_min        <= '0;
         r_hour       <= '0;
         r_sec_tick   <= 1'b0;
         r_min_carry  <= 1'b0;
         r_hour_carry <= 1'b0;
         r_day_wrap   <= 1'b0;
         r_load_err   <= 1'b0;
      end else begin
         r_presc      <= w_presc_nxt;
         r_sec        <= w_sec_nxt;
         r_min        <= w_min_nxt;
         r_hour       <= w_hour_nxt;
         r_sec_tick   <= w_adv;
         r_min_carry  <= w_sec_wrap;
         r_hour_carry <= w_min_wrap;
         r_day_wrap   <= w_hour_wrap;
         r_load_err   <= w_load_bad;
      end
   end

   // Load handshake state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Load handshake next state: any accepted request costs one busy cycle
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (load_valid) w_state_nxt = StBusy;
         StBusy:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Load handshake outputs
   always_comb begin
      load_ready = (r_state == StIdle);
   end

   assign load_err   = r_load_err;
   assign sec        = r_sec;
   assign min        = r_min;
   assign hour       = r_hour;
   assign sec_tick   = r_sec_tick;
   assign min_carry  = r_min_carry;
   assign hour_carry = r_hour_carry;
   assign day_wrap   = r_day_wrap;

`ifdef WATCH_ALARM_EN
   logic       r_alarm_armed;
   logic [5:0] r_alarm_min;
   logic [4:0] r_alarm_hour;
   logic       r_alarm;
   logic       w_match;

   // Fires only when the time actually changes into hh:mm:00, not while it sits there
   assign w_match = r_alarm_armed & (w_load_ok | w_adv) & (w_sec_nxt == 6'd0) &
                    (w_min_nxt == r_alarm_min) & (w_hour_nxt == r_alarm_hour);

   // Alarm registers: a match takes priority over a coincident clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alarm_armed <= 1'b0;
         r_alarm_min   <= '0;
         r_alarm_hour  <= '0;
         r_alarm       <= 1'b0;
      end else begin
         if (alarm_set) begin
            r_alarm_armed <= 1'b1;
            r_alarm_min   <= alarm_min;
            r_alarm_hour  <= alarm_hour;
         end
         if (w_match) begin
            r_alarm <= 1'b1;
         end else if (alarm_clr) begin
            r_alarm <= 1'b0;
         end
      end
   end

   assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_watch_timekeeper.sv
// tb_watch_timekeeper: two DUTs (PRESCALE=4 and PRESCALE=1) share stimulus and
// are compared every cycle against a model that keeps time as seconds-of-day.
module tb_watch_timekeeper;

   localparam int DAY = 86400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, run, load_valid;
   logic [5:0] load_sec, load_min;
   logic [4:0] load_hour;
   logic       d_ready [2];
   logic       d_err   [2];
   logic [5:0] d_sec   [2];
   logic [5:0] d_min   [2];
   logic [4:0] d_hour  [2];
   logic       d_st    [2];
   logic       d_mc    [2];
   logic       d_hc    [2];
   logic       d_dw    [2];
`ifdef WATCH_ALARM_EN
   logic       alarm_set, alarm_clr;
   logic [5:0] alarm_min;
   logic [4:0] alarm_hour;
   logic       d_alarm [2];
`endif

   watch_timekeeper #(.PRESCALE(4)) u_dut_p4 (
      .clk(clk), .rst(rst), .run(run), .load_valid(load_valid), .load_ready(d_ready[0]),
      .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour), .load_err(d_err[0]),
      .sec(d_sec[0]), .min(d_min[0]), .hour(d_hour[0]), .sec_tick(d_st[0]),
      .min_carry(d_mc[0]), .hour_carry(d_hc[0]), .day_wrap(d_dw[0])
`ifdef WATCH_ALARM_EN
      , .alarm_set(alarm_set), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
      .alarm_clr(alarm_clr), .alarm(d_alarm[0])
`endif
   );

   watch_timekeeper #(.PRESCALE(1)) u_dut_p1 (
      .clk(clk), .rst(rst), .run(run), .load_valid(load_valid), .load_ready(d_ready[1]),
      .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour), .load_err(d_err[1]),
      .sec(d_sec[1]), .min(d_min[1]), .hour(d_hour[1]), .sec_tick(d_st[1]),
      .min_carry(d_mc[1]), .hour_carry(d_hc[1]), .day_wrap(d_dw[1])
`ifdef WATCH_ALARM_EN
      , .alarm_set(alarm_set), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
      .alarm_clr(alarm_clr), .alarm(d_alarm[1])
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int k, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s inst=%0d got=%0d expected=%0d at %0t", name, k, got, exp, $time);
      end
   endtask

   // Model state: time as seconds of the day, prescaler count, busy flag, pulses
   bit m_valid = 1'b0;
   int m_t [2];
   int m_pc [2];
   bit m_busy [2], m_st [2], m_mc [2], m_hc [2], m_dw [2], m_err [2];
`ifdef WATCH_ALARM_EN
   bit m_armed [2], m_alarm [2];
   int m_am [2], m_ah [2];
`endif

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int p;
         bit accept, ok, tick, changed;
         p = (k == 0) ? 4 : 1;
         if (rst) begin
            m_valid = 1'b1;
            m_t[k] = 0; m_pc[k] = 0; m_busy[k] = 0;
            m_st[k] = 0; m_mc[k] = 0; m_hc[k] = 0; m_dw[k] = 0; m_err[k] = 0;
`ifdef WATCH_ALARM_EN
            m_armed[k] = 0; m_alarm[k] = 0; m_am[k] = 0; m_ah[k] = 0;
`endif
         end else begin
            accept  = load_valid && !m_busy[k];
            ok      = accept && load_sec < 60 && load_min < 60 && load_hour < 24;
            tick    = run && (m_pc[k] == p - 1);
            changed = 1'b0;
            m_st[k] = 0; m_mc[k] = 0; m_hc[k] = 0; m_dw[k] = 0;
            m_err[k]  = accept && !ok;
            m_busy[k] = accept;
            if (ok) begin
               m_t[k]  = int'(load_hour) * 3600 + int'(load_min) * 60 + int'(load_sec);
               m_pc[k] = 0;
               changed = 1'b1;
            end else begin
               if (run) m_pc[k] = (m_pc[k] + 1) % p;
               if (tick) begin
                  m_t[k]  = (m_t[k] + 1) % DAY;
                  m_st[k] = 1;
                  m_mc[k] = (m_t[k] % 60) == 0;
                  m_hc[k] = (m_t[k] % 3600) == 0;
                  m_dw[k] = m_t[k] == 0;
                  changed = 1'b1;
               end
            end
`ifdef WATCH_ALARM_EN
            if (m_armed[k] && changed && m_t[k] % 60 == 0 && (m_t[k] / 60) % 60 == m_am[k] &&
                m_t[k] / 3600 == m_ah[k])
               m_alarm[k] = 1;
            else if (alarm_clr)
               m_alarm[k] = 0;
            if (alarm_set) begin
               m_armed[k] = 1; m_am[k] = int'(alarm_min); m_ah[k] = int'(alarm_hour);
            end
`endif
         end
      end
   end

   // Compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         for (int k = 0; k < 2; k++) begin
            chk("sec",        k, int'(d_sec[k]),   m_t[k] % 60);
            chk("min",        k, int'(d_min[k]),   (m_t[k] / 60) % 60);
            chk("hour",       k, int'(d_hour[k]),  m_t[k] / 3600);
            chk("sec_tick",   k, int'(d_st[k]),    int'(m_st[k]));
            chk("min_carry",  k, int'(d_mc[k]),    int'(m_mc[k]));
            chk("hour_carry", k, int'(d_hc[k]),    int'(m_hc[k]));
            chk("day_wrap",   k, int'(d_dw[k]),    int'(m_dw[k]));
            chk("load_err",   k, int'(d_err[k]),   int'(m_err[k]));
            chk("load_ready", k, int'(d_ready[k]), int'(!m_busy[k]));
`ifdef WATCH_ALARM_EN
            chk("alarm",      k, int'(d_alarm[k]), int'(m_alarm[k]));
`endif
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_load(input int h, input int m, input int s);
      load_valid = 1'b1;
      load_hour = 5'(h); load_min = 6'(m); load_sec = 6'(s);
      step();
      load_valid = 1'b0;
   endtask

   initial begin
      int first_tick, last_tick, n_ticks, gap_bad, w;
      rst = 1'b1; run = 1'b0; load_valid = 1'b0;
      load_sec = '0; load_min = '0; load_hour = '0;
`ifdef WATCH_ALARM_EN
      alarm_set = 1'b0; alarm_clr = 1'b0; alarm_min = '0; alarm_hour = '0;
`endif
      step(); step();
      chk("lit_reset_sec",   0, int'(d_sec[0]), 0);
      chk("lit_reset_ready", 0, int'(d_ready[0]), 1);
      chk("lit_reset_err",   1, int'(d_err[1]), 0);

      // Free run with PRESCALE=4: four ticks in 16 cycles, 4 apart
      rst = 1'b0; run = 1'b1;
      first_tick = -1; last_tick = -1; n_ticks = 0; gap_bad = 0;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (d_st[0]) begin
            if (first_tick < 0) first_tick = c;
            else if (c - last_tick != 4) gap_bad++;
            last_tick = c;
            n_ticks++;
         end
      end
      chk("lit_run16_sec",   0, int'(d_sec[0]), 4);
      chk("lit_run16_ticks", 0, n_ticks, 4);
      chk("lit_run16_first", 0, first_tick, 4);
      chk("lit_run16_gaps",  0, gap_bad, 0);
      chk("lit_run16_sec",   1, int'(d_sec[1]), 16);

      // Out-of-range load while stopped
      run = 1'b0;
      do_load(5, 5, 60);
      chk("lit_bad_err",   0, int'(d_err[0]), 1);
      chk("lit_bad_ready", 0, int'(d_ready[0]), 0);
      chk("lit_bad_sec",   0, int'(d_sec[0]), 4);
      chk("lit_bad_min",   0, int'(d_min[0]), 0);
      step();
      chk("lit_bad_err2",   0, int'(d_err[0]), 0);
      chk("lit_bad_ready2", 0, int'(d_ready[0]), 1);

      // Full-day rollover on the PRESCALE=1 instance
      run = 1'b1;
      do_load(23, 59, 58);
      chk("lit_roll_load_sec", 1, int'(d_sec[1]), 58);
      chk("lit_roll_load_st",  1, int'(d_st[1]), 0);
      step();
      chk("lit_roll_59", 1, int'(d_sec[1]), 59);
      step();
      chk("lit_roll_hms", 1, int'(d_hour[1]) * 3600 + int'(d_min[1]) * 60 + int'(d_sec[1]), 0);
      chk("lit_roll_pulses", 1, int'({d_st[1], d_mc[1], d_hc[1], d_dw[1]}), 15);

      // Load when the PRESCALE=4 prescaler sits at its last count
      for (w = 0; w < 20 && !(m_pc[0] == 3 && !m_busy[0]); w++) step();
      chk("lit_pc3_found", 0, int'(w < 20), 1);
      do_load(10, 20, 30);
      chk("lit_ld_hms", 0, int'(d_hour[0]) * 3600 + int'(d_min[0]) * 60 + int'(d_sec[0]),
          10 * 3600 + 20 * 60 + 30);
      chk("lit_ld_st", 0, int'(d_st[0]), 0);
      for (w = 1; w <= 10; w++) begin
         step();
         if (d_st[0]) break;
      end
      chk("lit_ld_next_tick", 0, w, 4);
      chk("lit_ld_next_sec",  0, int'(d_sec[0]), 31);

      // Freeze mid-count: prescaler at 2, then resume needs only 2 more cycles
      step(); step();
      run = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("lit_frz_st",  0, int'(d_st[0]), 0);
         chk("lit_frz_sec", 0, int'(d_sec[0]), 31);
      end
      run = 1'b1;
      for (w = 1; w <= 10; w++) begin
         step();
         if (d_st[0]) break;
      end
      chk("lit_resume_tick", 0, w, 2);
      chk("lit_resume_sec",  0, int'(d_sec[0]), 32);

`ifdef WATCH_ALARM_EN
      // Alarm at 07:30 on the PRESCALE=1 instance
      run = 1'b0;
      alarm_set = 1'b1; alarm_min = 6'd30; alarm_hour = 5'd7;
      step();
      alarm_set = 1'b0;
      run = 1'b1;
      do_load(7, 29, 59);
      chk("lit_al_before", 1, int'(d_alarm[1]), 0);
      step();
      chk("lit_al_fire", 1, int'(d_alarm[1]), 1);
      step(); step();
      chk("lit_al_hold", 1, int'(d_alarm[1]), 1);
      alarm_clr = 1'b1;
      step();
      alarm_clr = 1'b0;
      chk("lit_al_clr", 1, int'(d_alarm[1]), 0);
      rst = 1'b1;
      step();
      rst = 1'b0; run = 1'b0;
      chk("lit_al_rst_sec", 1, int'(d_sec[1]), 0);
      do_load(7, 30, 0);
      chk("lit_al_disarmed", 1, int'(d_alarm[1]), 0);
`endif

      // Randomised phase
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         int mode;
         rst = ($urandom_range(0, 599) == 0);
         run = ($urandom_range(0, 9) != 0);
         load_valid = ($urandom_range(0, 11) == 0);
         mode = $urandom_range(0, 9);
         if (mode == 0) begin
            load_sec  = 6'($urandom_range(0, 63));
            load_min  = 6'($urandom_range(0, 63));
            load_hour = 5'($urandom_range(24, 31));
            if ($urandom_range(0, 1) == 1) begin
               load_hour = 5'($urandom_range(0, 23));
               load_min  = 6'($urandom_range(60, 63));
            end
         end else if (mode <= 3) begin
            load_sec  = 6'($urandom_range(54, 59));
            load_min  = 6'($urandom_range(58, 59));
            load_hour = 5'($urandom_range(22, 23));
         end else begin
            load_sec  = 6'($urandom_range(0, 59));
            load_min  = 6'($urandom_range(0, 59));
            load_hour = 5'($urandom_range(0, 23));
         end
`ifdef WATCH_ALARM_EN
         alarm_set  = ($urandom_range(0, 49) == 0);
         alarm_clr  = ($urandom_range(0, 19) == 0);
         alarm_min  = 6'($urandom_range(0, 1) == 1 ? 0 : $urandom_range(0, 59));
         alarm_hour = 5'($urandom_range(0, 1) == 1 ? 23 : $urandom_range(0, 23));
`endif
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/watch_timekeeper.md
Name: watch_timekeeper

Overview:
Parametrised successor to the ripple-clocked seconds ring counters. It keeps seconds, minutes and hours as binary counters, all on one clock. A built-in prescaler derives the 1 Hz tick from clk, so no derived clocks are needed. It sits between the LA/IO control bits and the display/IO pads, and supports run/stop, a validated time-load handshake and cascade carry pulses.

Parameters:
PRESCALE, 32768, clk cycles per seconds tick (>=1; 1 = tick every enabled cycle)
SEC_MAX, 60, seconds modulus (2..64)
MIN_MAX, 60, minutes modulus (2..64)
HOUR_MAX, 24, hours modulus (2..32)

Ports:
clk  in  1  single system clock; all state on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  1 = prescaler advances; 0 = time frozen, prescaler holds
load_valid  in  1  request to load time
load_ready  out  1  block can accept a load
load_sec  in  6  seconds value to load
load_min  in  6  minutes value to load
load_hour  in  5  hours value to load
load_err  out  1  one-cycle pulse: load rejected, value out of range
sec  out  6  current seconds, 0..SEC_MAX-1
min  out  6  current minutes, 0..MIN_MAX-1
hour  out  5  current hours, 0..HOUR_MAX-1
sec_tick  out  1  one-cycle pulse when seconds advance
min_carry  out  1  one-cycle pulse when seconds wrap SEC_MAX-1 -> 0
hour_carry  out  1  one-cycle pulse when minutes wrap
day_wrap  out  1  one-cycle pulse when hours wrap HOUR_MAX-1 -> 0

Behaviour:
- Reset (rst=1 at an edge): sec=min=hour=0, prescaler=0, all pulses 0, load_err=0, load_ready=1. Reset overrides load and run in the same cycle.
- Prescaler: counts 0..PRESCALE-1 while run=1. In the cycle it holds PRESCALE-1 with run=1, it wraps to 0 and the registered tick takes effect at that edge. sec_tick is asserted in the cycle after the seconds update, so it is aligned with the new sec value.
- With run=0, the prescaler, counters and pulses hold (pulses 0). Run resumes from the held prescaler value, with no extra tick.
- Cascade happens in the same edge:
  - tick & sec==SEC_MAX-1 -> sec=0, min increments, min_carry=1.
  - If min also wraps -> hour_carry=1 and hour increments.
  - If hour also wraps -> day_wrap=1.
  - A full 23:59:59 -> 00:00:00 rollover raises all four pulses in the same cycle.
- Load handshake FSM:
  - IDLE: load_ready=1. A load is accepted on load_valid & load_ready.
  - Accept, all fields in range: counters take the load values, the prescaler clears to 0, and the state goes to BUSY.
  - Accept, any field >= its MAX: counters unchanged, load_err=1 for one cycle, state goes to BUSY.
  - BUSY: load_ready=0 for exactly one cycle, then returns to IDLE. Back-to-back loads are therefore spaced at least 2 cycles apart.
- A load and a tick in the same cycle: the load wins and the tick is discarded (no pulses that cycle).
- A load is accepted regardless of run.
- load_valid while load_ready=0 is ignored; the requester must hold load_valid until ready.
- Widths are fixed at 6/6/5. Counters never hold values >= their MAX.

Optional Feature:
Macro WATCH_ALARM_EN.
- Defined: adds inputs alarm_set (1), alarm_min (6), alarm_hour (5), alarm_clr (1) and output alarm (1).
  - alarm_set=1 latches alarm_min and alarm_hour into internal regs and arms the alarm. Reset disarms it and clears the regs to 0.
  - alarm goes to 1 on the edge where the counters become hour==alarm_hour, min==alarm_min, sec==0 while armed, whether by tick or by load. It then stays 1 until alarm_clr=1 or reset.
  - alarm_clr and a match in the same cycle: the match wins.
- Undefined: none of these ports or regs exist, and behaviour is otherwise identical.

Test Plan:
1. PRESCALE=4, rst then run=1 for 16 cycles -> sec=4, exactly 4 sec_tick pulses, each 4 cycles apart.
2. PRESCALE=1, load 23:59:58 then run 2 cycles -> 23:59:59, then 00:00:00 with sec_tick, min_carry, hour_carry and day_wrap all high in one cycle.
3. load_valid with load_sec=60 -> load_err=1 for one cycle, time unchanged, load_ready=0 for the next cycle then 1.
4. PRESCALE=4, run=1, load 10:20:30 in the cycle the prescaler is at 3 -> time=10:20:30, no sec_tick; next tick arrives 4 cycles later with sec=31.
5. run toggled 0 for 10 cycles mid-count -> sec and prescaler frozen, no pulses; after run=1 the tick arrives after the remaining prescaler count only.
6. WATCH_ALARM_EN, alarm_set at 07:30, load 07:29:59, PRESCALE=1, run -> alarm=1 at 07:30:00 and holds until alarm_clr; rst mid-count -> all outputs 0 and the alarm disarmed.
